// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, GF(2^8) helpers and S-box tables
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef logic [127:0] aes_state_t;

  // Byte s[r,c] sits at index 4c+r; byte 0 occupies bits [127:120].
  function automatic int byte_pos(input int r, input int c);
    return 8 * (15 - (4 * c + r));
  endfunction

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // Entry x lives at bits [8*(255-x) +: 8], and 255-x == ~x for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[byte_pos(r, c) +: 8] = s[byte_pos(r, (c - r + 4) % 4) +: 8];
    return o;
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[byte_pos(0, c) +: 8];
      a1 = s[byte_pos(1, c) +: 8];
      a2 = s[byte_pos(2, c) +: 8];
      a3 = s[byte_pos(3, c) +: 8];
      o[byte_pos(0, c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[byte_pos(1, c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[byte_pos(2, c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[byte_pos(3, c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - 8-bit combinational AES inverse S-box
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = inv_sbox(a);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 decryption, one round per clock
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes_inv_cipher_iter: only NR=10 (AES-128) is supported");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic [3:0] cnt_q, cnt_d;
  aes_state_t state_q, state_d;
  aes_state_t sr, sb, ark, mc;

  // Shared round datapath; FINAL taps it before InvMixColumns.
  assign sr = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .a (sr[8*i +: 8]),
      .y (sb[8*i +: 8])
    );
  end

  assign ark = sb ^ rk_in;
  assign mc  = inv_mix_columns(ark);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      cnt_q   <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd10;
    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_data ^ rk_in;
          cnt_d   = 4'd9;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_idx  = cnt_q;
        state_d = mc;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        rk_idx  = 4'd0;
        state_d = ark;
        fsm_d   = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign out_data = state_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - self-checking bench for aes_inv_cipher_iter
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0]   m_sbox [256];
  logic [127:0] m_rk   [11];
  int           rk_seq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key store served combinationally from the model's schedule.
  assign rk_in = (rk_idx <= 4'd10) ? m_rk[rk_idx] : 128'h0;

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_in     (rk_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vt [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic m_build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic m_set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) m_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // Forward cipher; the DUT output is judged by recovering the plaintext.
  function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ m_rk[0][127-8*k -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = m_sbox[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ m_rk[rnd][127-8*k -: 8];
    end
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // Starts at a negedge; returns at the negedge where out_valid is first seen.
  task automatic do_block(input logic [127:0] ct, output logic [127:0] res,
                          output int lat, output int acc_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    rk_seq.delete();
    rk_seq.push_back(int'(rk_idx));
    in_data  = ct;
    in_valid = 1'b1;
    acc_cyc  = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    rk_seq.push_back(int'(rk_idx));
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      rk_seq.push_back(int'(rk_idx));
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    res = out_data;
  endtask

  logic [127:0] res, held, pt, ct, key;
  int lat, acc, prev_acc;

  initial begin
    vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32};
    vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    m_build_sbox();
    m_set_key(vt[0].key);
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_rk_idx", rk_idx, 10);
    rst_n = 1'b1;
    @(negedge clk);
    chk("model_c1_rk10", m_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    for (int i = 0; i < 3; i++) begin
      m_set_key(vt[i].key);
      chk($sformatf("model_ct_%0d", i), m_encrypt(vt[i].pt), vt[i].ct);
      do_block(vt[i].ct, res, lat, acc);
      chk($sformatf("vec_pt_%0d", i), res, vt[i].pt);
      chk($sformatf("vec_latency_%0d", i), lat, 10);
      if (i == 0) begin
        @(negedge clk);
        for (int k = 0; k < 12; k++)
          chk($sformatf("rk_idx_seq_%0d", k), (k < rk_seq.size()) ? rk_seq[k] : -1,
              (k == 0 || k == 11) ? 10 : 10 - k);
      end
    end

    // Backpressure: hold the result five cycles while poking in_valid.
    m_set_key(vt[0].key);
    @(negedge clk);
    out_ready = 1'b0;
    do_block(vt[0].ct, res, lat, acc);
    held = out_data;
    chk("bp_result", held, vt[0].pt);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      in_data  = 128'hdeadbeef;
      @(negedge clk);
      chk("bp_out_data_stable", out_data, held);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    chk("bp_no_spurious_job", {out_valid, in_ready, rk_idx}, {1'b0, 1'b1, 4'd10});

    // Reset in the middle of the round sequence.
    in_data = vt[0].ct; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_block(vt[0].ct, res, lat, acc);
    chk("midrst_after_pt", res, vt[0].pt);

    // Back-to-back random keys/plaintexts with out_ready held high.
    @(negedge clk);
    prev_acc = -1;
    for (int i = 0; i < 300; i++) begin
      while (!in_ready) @(negedge clk);
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      m_set_key(key);
      ct = m_encrypt(pt);
      do_block(ct, res, lat, acc);
      chk($sformatf("rand_pt_%0d", i), res, pt);
      if (prev_acc >= 0) chk($sformatf("rand_interval_%0d", i), acc - prev_acc, 12);
      prev_acc = acc;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
